// File: rtl/sprite_attr_fetch.sv
// Sprite attribute table scanner: once per video line, reads each 2-word entry
// from the attribute RAM and hands sprites visible on that line to the renderer.
module sprite_attr_fetch #(
  parameter int NUM_SPRITES  = 128,
  parameter int MAX_PER_LINE = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_i,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        spr_valid_o,
  input  logic        spr_ready_i,
  output logic [6:0]  spr_idx_o,
  output logic [11:0] spr_addr_o,
  output logic        spr_mode_o,
  output logic [9:0]  spr_x_o,
  output logic [5:0]  spr_row_o,
  output logic        spr_hflip_o,
  output logic [1:0]  spr_z_o,
  output logic [3:0]  spr_coll_o,
  output logic [3:0]  spr_pal_o,
  output logic [1:0]  spr_width_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CW = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_EVAL, S_OUT, S_DONE
  } state_t;

  state_t          state, nxt;
  logic [9:0]      line_q;
  logic [6:0]      idx;
  logic [CW-1:0]   cnt;
  logic [11:0]     w0_addr;
  logic            w0_mode;
  logic [9:0]      w0_x;

  logic            start, adv, load, hs;
  logic            last_idx, last_cnt;

  // Entry decode; rd_data_i holds word1 while in EVAL.
  logic [6:0]      h;
  logic [9:0]      diff;
  logic [9:0]      row_full;
  logic            vis;

  assign h        = 7'd8 << rd_data_i[31:30];
  assign diff     = line_q - rd_data_i[9:0];
  assign row_full = rd_data_i[17] ? ({3'b0, h} - 10'd1 - diff) : diff;
  assign vis      = (rd_data_i[19:18] != 2'b00) && (diff < {3'b0, h});

  assign last_idx = (idx == 7'(NUM_SPRITES - 1));
  assign last_cnt = (cnt == CW'(MAX_PER_LINE - 1));

  logic unused_bits;
  assign unused_bits = ^{rd_data_i[14:12], row_full[9:6]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt   = state;
    start = 1'b0;
    adv   = 1'b0;
    load  = 1'b0;
    hs    = 1'b0;
    case (state)
      S_IDLE: if (line_start_i) begin
        start = 1'b1;
        nxt   = S_RD0;
      end
      S_RD0:  nxt = S_RD1;
      S_RD1:  nxt = S_EVAL;
      S_EVAL: begin
        if (vis) begin
          load = 1'b1;
          nxt  = S_OUT;
        end else if (last_idx) begin
          nxt = S_DONE;
        end else begin
          adv = 1'b1;
          nxt = S_RD0;
        end
      end
      S_OUT: if (spr_ready_i) begin
        hs = 1'b1;
        if (last_cnt || last_idx) begin
          nxt = S_DONE;
        end else begin
          adv = 1'b1;
          nxt = S_RD0;
        end
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // A new line start wins over everything, including a same-cycle handshake.
    if (line_start_i && state != S_IDLE) begin
      start = 1'b1;
      adv   = 1'b0;
      load  = 1'b0;
      hs    = 1'b0;
      nxt   = S_RD0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q      <= '0;
      idx         <= '0;
      cnt         <= '0;
      w0_addr     <= '0;
      w0_mode     <= 1'b0;
      w0_x        <= '0;
      rd_addr_o   <= '0;
      spr_idx_o   <= '0;
      spr_addr_o  <= '0;
      spr_mode_o  <= 1'b0;
      spr_x_o     <= '0;
      spr_row_o   <= '0;
      spr_hflip_o <= 1'b0;
      spr_z_o     <= '0;
      spr_coll_o  <= '0;
      spr_pal_o   <= '0;
      spr_width_o <= '0;
    end else begin
      if (start) begin
        line_q <= line_i;
        idx    <= '0;
        cnt    <= '0;
      end else begin
        if (adv) idx <= idx + 7'd1;
        if (hs)  cnt <= cnt + CW'(1);
      end

      // Address is set up on the way into each read state so it is valid in-state.
      if (nxt == S_RD0)      rd_addr_o <= start ? 8'd0 : {idx + 7'd1, 1'b0};
      else if (nxt == S_RD1) rd_addr_o <= {idx, 1'b1};

      if (state == S_RD1) begin
        w0_addr <= rd_data_i[11:0];
        w0_mode <= rd_data_i[15];
        w0_x    <= rd_data_i[25:16];
      end

      if (load) begin
        spr_idx_o   <= idx;
        spr_addr_o  <= w0_addr;
        spr_mode_o  <= w0_mode;
        spr_x_o     <= w0_x;
        spr_row_o   <= row_full[5:0];
        spr_hflip_o <= rd_data_i[16];
        spr_z_o     <= rd_data_i[19:18];
        spr_coll_o  <= rd_data_i[23:20];
        spr_pal_o   <= rd_data_i[27:24];
        spr_width_o <= rd_data_i[29:28];
      end
    end
  end

  assign rd_en_o     = (state == S_RD0) || (state == S_RD1);
  assign busy_o      = (state == S_RD0) || (state == S_RD1) ||
                       (state == S_EVAL) || (state == S_OUT);
  assign spr_valid_o = (state == S_OUT);
  assign done_o      = (state == S_DONE);

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Bench for sprite_attr_fetch: RAM model, table-driven decode vectors, corner
// sequences and randomized tables checked against a list-based reference.
module tb_sprite_attr_fetch;

  localparam int NS  = 128;
  localparam int MAX = 16;

  logic        clk = 1'b0;
  logic        rst, line_start, rd_en, spr_valid, spr_ready;
  logic [9:0]  line;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [6:0]  spr_idx;
  logic [11:0] spr_addr;
  logic        spr_mode, spr_hflip, busy, done;
  logic [9:0]  spr_x;
  logic [5:0]  spr_row;
  logic [1:0]  spr_z, spr_width;
  logic [3:0]  spr_coll, spr_pal;

  sprite_attr_fetch #(.NUM_SPRITES(NS), .MAX_PER_LINE(MAX)) dut (
    .clk_i(clk), .rst_i(rst), .line_start_i(line_start), .line_i(line),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .spr_valid_o(spr_valid), .spr_ready_i(spr_ready), .spr_idx_o(spr_idx),
    .spr_addr_o(spr_addr), .spr_mode_o(spr_mode), .spr_x_o(spr_x),
    .spr_row_o(spr_row), .spr_hflip_o(spr_hflip), .spr_z_o(spr_z),
    .spr_coll_o(spr_coll), .spr_pal_o(spr_pal), .spr_width_o(spr_width),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [6:0]  idx;
    logic [11:0] addr;
    logic        mode;
    logic [9:0]  x;
    logic [5:0]  row;
    logic        hflip;
    logic [1:0]  z;
    logic [3:0]  coll;
    logic [3:0]  pal;
    logic [1:0]  width;
  } desc_t;

  typedef struct {
    int ent; int y; int hcode; int vflip; int z; int ln; int vis; int row;
  } vec_t;

  desc_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic desc_t cur();
    desc_t d;
    d.idx = spr_idx;   d.addr = spr_addr; d.mode = spr_mode; d.x = spr_x;
    d.row = spr_row;   d.hflip = spr_hflip; d.z = spr_z; d.coll = spr_coll;
    d.pal = spr_pal;   d.width = spr_width;
    return d;
  endfunction

  function automatic logic [31:0] mk_w0(input logic [11:0] a, input logic m, input logic [9:0] x);
    return {6'b0, x, m, 3'b0, a};
  endfunction

  function automatic logic [31:0] mk_w1(input logic [9:0] y, input logic hf, input logic vf,
      input logic [1:0] z, input logic [3:0] coll, input logic [3:0] pal,
      input logic [1:0] wc, input logic [1:0] hc);
    return {hc, wc, pal, coll, z, vf, hf, 6'b0, y};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  // Reference: walk the table in order, keep every visible entry, cap at MAX.
  task automatic build_expected(input logic [9:0] ln);
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      logic [31:0] w0, w1;
      int hgt, d, r;
      desc_t e;
      if (exp_q.size() >= MAX) break;
      w0  = mem[2*i];
      w1  = mem[2*i+1];
      hgt = 8 * (1 << int'(w1[31:30]));
      d   = (int'(ln) - int'(w1[9:0]) + 1024) % 1024;
      if (w1[19:18] != 2'b00 && d < hgt) begin
        r = (w1[17] ? (hgt - 1 - d) : d) % 64;
        e.idx = 7'(i); e.addr = w0[11:0]; e.mode = w0[15]; e.x = w0[25:16];
        e.row = 6'(r); e.hflip = w1[16]; e.z = w1[19:18]; e.coll = w1[23:20];
        e.pal = w1[27:24]; e.width = w1[29:28];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_line(input logic [9:0] ln);
    @(negedge clk); line_start = 1'b1; line = ln; spr_ready = 1'b0;
    @(negedge clk); line_start = 1'b0;
  endtask

  // Called on the first negedge after the start edge (cycle T+1 = k 1).
  task automatic monitor(input int rmode, input bit chk_addr, output int n_hs,
      output int first_k, output int done_k, output int n_rd, output logic [5:0] last_row);
    desc_t held;
    bit hold_pend, pend, hs;
    int total;
    total = exp_q.size();
    n_hs = 0; first_k = -1; done_k = -1; n_rd = 0; last_row = '0;
    hold_pend = 0; pend = 0; held = '0;
    for (int k = 1; k <= 3000; k++) begin
      case (rmode)
        0:       spr_ready = 1'b1;
        1:       spr_ready = 1'($urandom_range(0, 1));
        default: spr_ready = pend;
      endcase
      if (k == 1) chk("busy_start", 64'(busy), 64'(1));
      if (rd_en) begin
        if (chk_addr) chk("rd_addr_seq", 64'(rd_addr), 64'(n_rd));
        n_rd++;
      end
      if (spr_valid) begin
        if (first_k < 0) first_k = k;
        chk("no_rd_in_out", 64'(rd_en), 64'(0));
        if (hold_pend) chk("desc_stable", 64'(cur()), 64'(held));
      end else if (hold_pend) begin
        chk("valid_held", 64'(spr_valid), 64'(1));
      end
      hs = spr_valid && spr_ready;
      if (hs) begin
        if (exp_q.size() == 0) chk("desc_count", 64'(n_hs + 1), 64'(total));
        else                   chk("desc", 64'(cur()), 64'(exp_q.pop_front()));
        last_row = spr_row;
        n_hs++;
      end
      hold_pend = spr_valid && !hs;
      pend      = hold_pend;
      held      = cur();
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    if (done_k < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: no done_o within 3000 cycles");
    end
    chk("desc_remaining", 64'(exp_q.size()), 64'(0));
    spr_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_done", 64'({busy, done, spr_valid, rd_en}), 64'(0));
  endtask

  task automatic run_scan(input logic [9:0] ln, input int rmode, input bit chk_addr,
      output int n_hs, output int first_k, output int done_k, output int n_rd,
      output logic [5:0] last_row);
    build_expected(ln);
    start_line(ln);
    monitor(rmode, chk_addr, n_hs, first_k, done_k, n_rd, last_row);
  endtask

  task automatic wait_valid(input string nm, output int k);
    for (k = 1; k <= 600; k++) begin
      if (spr_valid) return;
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL %s: spr_valid_o never rose", nm);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_hs, fk, dk, nrd, k, ndone;
    logic [5:0] lr;
    logic [9:0] ln;
    desc_t held;
    vec_t vt[9];

    vt[0] = '{64,  300,  3, 1, 1, 310,  1, 53};
    vt[1] = '{64,  300,  3, 0, 1, 310,  1, 10};
    vt[2] = '{5,   1020, 0, 0, 2, 2,    1, 6};
    vt[3] = '{5,   1020, 0, 0, 2, 4,    0, 0};
    vt[4] = '{127, 100,  1, 1, 1, 115,  1, 0};
    vt[5] = '{127, 100,  1, 1, 1, 116,  0, 0};
    vt[6] = '{10,  50,   0, 0, 0, 50,   0, 0};
    vt[7] = '{0,   0,    2, 0, 3, 31,   1, 31};
    vt[8] = '{33,  1023, 0, 1, 1, 1023, 1, 7};

    rst = 1'b1; line_start = 1'b0; line = '0; spr_ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({spr_valid, busy, done, rd_en}), 64'(0));
    chk("reset_addr", 64'(rd_addr), 64'(0));
    chk("reset_desc", 64'(cur()), 64'(0));
    rst = 1'b0;

    // First-sprite latency and end-of-scan timing with a late ready.
    clear_mem();
    mem[0] = mk_w0(12'd2, 1'b1, 10'd0);
    mem[1] = mk_w1(10'd3, 1'b0, 1'b0, 2'd3, 4'd0, 4'd0, 2'd0, 2'd0);
    run_scan(10'd5, 2, 1'b0, n_hs, fk, dk, nrd, lr);
    chk("lat_first_valid", 64'(fk), 64'(4));
    chk("lat_hs", 64'(n_hs), 64'(1));
    chk("lat_row", 64'(lr), 64'(2));
    chk("lat_done", 64'(dk), 64'(4 + 1 + 127*3 + 1));

    // Empty table: fixed scan time, every word read in order.
    clear_mem();
    run_scan(10'd77, 0, 1'b1, n_hs, fk, dk, nrd, lr);
    chk("empty_hs", 64'(n_hs), 64'(0));
    chk("empty_done", 64'(dk), 64'(385));
    chk("empty_reads", 64'(nrd), 64'(256));

    // Decode vectors.
    for (int v = 0; v < 9; v++) begin
      clear_mem();
      mem[2*vt[v].ent]   = mk_w0(12'(vt[v].ent * 3), 1'(vt[v].ent), 10'(vt[v].ent + 7));
      mem[2*vt[v].ent+1] = mk_w1(10'(vt[v].y), 1'b1, 1'(vt[v].vflip), 2'(vt[v].z),
                                 4'h9, 4'h6, 2'd1, 2'(vt[v].hcode));
      run_scan(10'(vt[v].ln), 0, 1'b0, n_hs, fk, dk, nrd, lr);
      chk("vec_vis", 64'(n_hs), 64'(vt[v].vis));
      if (vt[v].vis != 0) chk("vec_row", 64'(lr), 64'(vt[v].row));
    end

    // Backpressure: descriptor held, no reads while stalled.
    clear_mem();
    mem[6] = mk_w0(12'h345, 1'b1, 10'd200);
    mem[7] = mk_w1(10'd98, 1'b1, 1'b0, 2'd2, 4'ha, 4'h5, 2'd3, 2'd0);
    build_expected(10'd100);
    start_line(10'd100);
    wait_valid("bp_valid", k);
    chk("bp_first_valid", 64'(k), 64'(13));
    held = cur();
    chk("bp_desc", 64'(held), 64'(exp_q[0]));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid_held", 64'({spr_valid, rd_en}), 64'(2'b10));
      chk("bp_stable", 64'(cur()), 64'(held));
    end
    spr_ready = 1'b1;
    @(negedge clk); spr_ready = 1'b0;
    chk("bp_valid_drop", 64'(spr_valid), 64'(0));
    ndone = 0;
    for (int c = 0; c < 500 && ndone == 0; c++) begin
      if (done) ndone++;
      else @(negedge clk);
    end
    chk("bp_done", 64'(ndone), 64'(1));

    // Per-line cap: 32 visible, only MAX delivered.
    clear_mem();
    for (int i = 0; i < 32; i++) begin
      mem[2*i]   = mk_w0(12'(i), 1'b0, 10'(i * 9));
      mem[2*i+1] = mk_w1(10'd200, 1'b0, 1'(i), 2'd1, 4'(i), 4'(i + 1), 2'd2, 2'd1);
    end
    run_scan(10'd205, 1, 1'b0, n_hs, fk, dk, nrd, lr);
    chk("cap_hs", 64'(n_hs), 64'(MAX));

    // Restart while a descriptor is pending, with a same-cycle ready.
    clear_mem();
    mem[1] = mk_w1(10'd20, 1'b0, 1'b0, 2'd1, 4'd1, 4'd1, 2'd0, 2'd0);
    mem[3] = mk_w1(10'd20, 1'b0, 1'b0, 2'd1, 4'd2, 4'd2, 2'd0, 2'd0);
    mem[4] = mk_w0(12'h0aa, 1'b1, 10'd300);
    mem[5] = mk_w1(10'd40, 1'b1, 1'b1, 2'd2, 4'd3, 4'd3, 2'd0, 2'd0);
    start_line(10'd20);
    wait_valid("abort_valid", k);
    chk("abort_pre_idx", 64'(spr_idx), 64'(0));
    line_start = 1'b1; line = 10'd40; spr_ready = 1'b1;
    @(negedge clk); line_start = 1'b0;
    chk("abort_drop", 64'({spr_valid, done, rd_en}), 64'(3'b001));
    chk("abort_addr", 64'(rd_addr), 64'(0));
    build_expected(10'd40);
    monitor(0, 1'b0, n_hs, fk, dk, nrd, lr);
    chk("abort_hs", 64'(n_hs), 64'(1));

    // line_start during DONE, then reset mid-scan.
    clear_mem();
    start_line(10'd9);
    ndone = 0;
    for (int c = 0; c < 500 && ndone == 0; c++) begin
      if (done) ndone++;
      else @(negedge clk);
    end
    chk("ds_done", 64'(ndone), 64'(1));
    line_start = 1'b1; line = 10'd10;
    @(negedge clk); line_start = 1'b0;
    chk("ds_restart", 64'({busy, rd_en, done}), 64'(3'b110));
    chk("ds_addr", 64'(rd_addr), 64'(0));
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_ctl", 64'({spr_valid, busy, done, rd_en}), 64'(0));
    chk("rst_mid_addr", 64'(rd_addr), 64'(0));
    ndone = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'(0));

    // Randomized tables and backpressure against the reference list.
    for (int it = 0; it < 15; it++) begin
      ln = 10'($urandom_range(0, 1023));
      for (int i = 0; i < NS; i++) begin
        mem[2*i]   = $urandom;
        mem[2*i+1] = $urandom;
        if ($urandom_range(0, 9) < 7) mem[2*i+1][9:0] = ln - 10'($urandom_range(0, 70));
      end
      run_scan(ln, 1, 1'b0, n_hs, fk, dk, nrd, lr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_attr_fetch.md
Name: sprite_attr_fetch

Overview:
- Reader side of the sprite attribute RAM: once per video line, scans the sprite attribute table, decodes each 2-word entry, and hands each sprite visible on that line to the sprite line renderer over a valid/ready interface.
- Drives the RAM read port: rd_en, rd_addr, rd_data with 1-cycle read latency.
- Signals completion so the renderer can finalise the line buffer.

Parameters:
NUM_SPRITES, 128, entries scanned per line (2 RAM words each, entry i at words 2i and 2i+1).
MAX_PER_LINE, 64, scan stops after this many accepted sprites.

Ports:
clk_i  in  1  clock (RAM read clock domain).
rst_i  in  1  synchronous, active-high reset.
line_start_i  in  1  one-cycle pulse; starts (or restarts) a scan.
line_i  in  10  line number, sampled on line_start_i.
rd_en_o  out  1  RAM read enable.
rd_addr_o  out  8  RAM word address.
rd_data_i  in  32  RAM data; valid the cycle after rd_en_o/rd_addr_o.
spr_valid_o  out  1  sprite descriptor valid.
spr_ready_i  in  1  renderer accepts descriptor.
spr_idx_o  out  7  sprite index.
spr_addr_o  out  12  pattern address (word0[11:0]).
spr_mode_o  out  1  1 = 8bpp (word0[15]).
spr_x_o  out  10  x position (word0[25:16]).
spr_row_o  out  6  pattern row to fetch, vflip already applied.
spr_hflip_o  out  1  word1[16].
spr_z_o  out  2  word1[19:18].
spr_coll_o  out  4  collision mask (word1[23:20]).
spr_pal_o  out  4  palette offset (word1[27:24]).
spr_width_o  out  2  width code (word1[29:28]); width = 8<<code.
busy_o  out  1  scan in progress.
done_o  out  1  one-cycle pulse at end of scan.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; index and count cleared.
- States: IDLE, RD0, RD1, EVAL, OUT, DONE. busy_o=1 in RD0..OUT.
- IDLE: on line_start_i, latch line_i, set idx=0, set cnt=0, go to RD0.
- RD0: rd_en_o=1, rd_addr_o=2*idx, go to RD1.
- RD1: rd_en_o=1, rd_addr_o=2*idx+1, capture rd_data_i as word0, go to EVAL.
- EVAL: rd_data_i is word1. Decode the entry:
  - Height h = 8<<word1[31:30].
  - diff = (line - word1[9:0]) mod 1024, computed 10-bit with wrap.
  - Visible iff z != 0 and diff < h.
  - row = vflip ? h-1-diff : diff, truncated to 6 bits.
  - If visible: register all spr_* fields and go to OUT.
  - Else if idx == NUM_SPRITES-1: go to DONE.
  - Else: idx++, go to RD0.
  - Each skipped sprite costs 3 cycles.
- OUT: spr_valid_o=1, and all spr_* outputs stay stable until spr_ready_i. On handshake:
  - cnt++.
  - If cnt+1 == MAX_PER_LINE or idx == NUM_SPRITES-1: go to DONE.
  - Else: idx++, go to RD0.
  - spr_valid_o drops the cycle after the handshake.
- DONE: done_o=1 for one cycle, go to IDLE.
- rd_en_o=0 outside RD0/RD1. rd_addr_o holds its last value.
- line_start_i while not IDLE: abort the scan, deassert spr_valid_o next cycle, no done_o, restart at RD0 with the new line. Restart has priority over a same-cycle handshake; the handshake is treated as not occurring.
- line_start_i in DONE: done_o still pulses, then the new scan starts from RD0 on the next cycle.
- rst_i mid-scan: return to the reset state immediately, with no done_o.
- Latency: line_start_i at cycle T → first rd_en_o at T+1 → earliest spr_valid_o at T+4.

Test Plan:
- Entry 0 = {addr 2, 8bpp, x 0, y 3, z 3, 8x8}, all other entries z=0; line 5 → spr_valid_o at T+4 with idx 0, row 2, addr 2, x 0. Handshake, then done_o at T+4+1+127*3+1.
- All entries z=0 → zero valid descriptors; done_o at exactly T+385; rd_addr_o steps through 0..255.
- Entry 64 = {y 300, 64x64, vflip 1}, line 310 → idx 64, row 53; repeat with vflip 0 → row 10.
- Wrap-around: y 1020, 8-high, line 2 → visible, row 6; line 4 → not visible.
- Backpressure: hold spr_ready_i low for 10 cycles → valid and fields stable, no RAM reads. 32 visible sprites with MAX_PER_LINE=16 → exactly 16 handshakes, then done_o.
- line_start_i pulsed mid-scan while in OUT → valid drops next cycle, no done_o, rd_addr_o restarts at 0, new line used.
